// File: rtl/twos_comp_seq_if.sv
// Request/response bundle for the sequential two's-complement converter.
// master = requester/consumer side, slave = converter side.
interface twos_comp_seq_if #(
    parameter int N_BITS = 8
);
    logic              start;
    logic [N_BITS-1:0] din;
    logic              busy;
    logic [N_BITS-1:0] dout;
    logic              valid;
    logic              ack;
    logic              ovf;

    modport master (
        output start, din, ack,
        input  busy, dout, valid, ovf
    );

    modport slave (
        input  start, din, ack,
        output busy, dout, valid, ovf
    );
endinterface

// File: rtl/twos_comp_seq.sv
// Sequential two's-complement converter: drives timing pulses into an external
// one's-complement latch array, then adds one bit-serially to the returned value.
module twos_comp_seq #(
    parameter int N_BITS = 8,
    parameter int PULSES = 9
) (
    input  logic               clk,
    input  logic               rst,
    twos_comp_seq_if.slave     bus,
    output logic [PULSES-1:0]  T,
    input  logic [N_BITS-1:0]  bbar_in
);

    localparam int IW = $clog2(N_BITS + 1);
    localparam logic [N_BITS-1:0] MOST_NEG = {1'b1, {(N_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PULSE,
        INC,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [N_BITS-1:0] hold_reg, hold_next;
    logic [N_BITS-1:0] work_reg, work_next;
    logic              carry_reg, carry_next;
    logic [IW-1:0]     k_reg, k_next;
    logic [IW-1:0]     i_reg, i_next;

    logic [PULSES-1:0] pulse_sel;
    logic [N_BITS-1:0] bit_sel;

    // One-hot decodes of the pulse index and the increment bit index.
    genvar gi;
    generate
        for (gi = 0; gi < PULSES; gi++) begin : g_pulse_dec
            assign pulse_sel[gi] = (k_reg == IW'(gi));
        end
        for (gi = 0; gi < N_BITS; gi++) begin : g_bit_dec
            assign bit_sel[gi] = (i_reg == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            k_reg     <= '0;
            i_reg     <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            work_reg  <= work_next;
            carry_reg <= carry_next;
            k_reg     <= k_next;
            i_reg     <= i_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        work_next  = work_reg;
        carry_next = carry_reg;
        k_next     = k_reg;
        i_next     = i_reg;
        T          = '0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    hold_next  = bus.din;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                T[0]       = 1'b1;
                k_next     = IW'(1);
                state_next = PULSE;
            end
            PULSE: begin
                T = pulse_sel;
                if (k_reg == IW'(N_BITS)) begin
                    work_next  = bbar_in;
                    carry_next = 1'b1;
                    i_next     = '0;
                    state_next = INC;
                end else begin
                    k_next = k_reg + IW'(1);
                end
            end
            INC: begin
                // Ripple the +1 one bit per cycle; final carry-out is dropped.
                work_next  = work_reg ^ (bit_sel & {N_BITS{carry_reg}});
                carry_next = (|(work_reg & bit_sel)) & carry_reg;
                i_next     = i_reg + IW'(1);
                if (i_reg == IW'(N_BITS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_reg != IDLE);
    assign bus.valid = (state_reg == DONE);
    assign bus.dout  = work_reg;
    assign bus.ovf   = (state_reg == DONE) && (hold_reg == MOST_NEG);

endmodule

// File: tb/tb_twos_comp_seq.sv
// Scoreboard bench for twos_comp_seq with a behavioural one's-complement latch array.
module tb_twos_comp_seq;

    localparam int N = 8;
    localparam int P = N + 1;

    typedef struct {
        logic [N-1:0] d;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] T;
    logic [N-1:0] bbar_in;
    logic [N-1:0] lat;
    logic [N-1:0] arr_b;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    twos_comp_seq_if #(.N_BITS(N)) bus();

    twos_comp_seq #(
        .N_BITS(N),
        .PULSES(P)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .T       (T),
        .bbar_in (bbar_in)
    );

    always #5 clk = ~clk;

    // Latch array: T[0] clears, T[k] sets bit k-1 when the B input bit is 0.
    always @(T or arr_b) begin
        if (T[0]) lat = '0;
        for (int k = 1; k < P; k++) begin
            if (T[k] && !arr_b[k-1]) lat[k-1] = 1'b1;
        end
    end
    assign bbar_in = lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected result per accepted output transfer.
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_xfer: got dout=%0h expected no transfer", bus.dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("xfer dout=%02h ovf=%b (expected %02h/%b)", bus.dout, bus.ovf, e.d, e.o);
                check("xfer_dout", 32'(bus.dout), 32'(e.d));
                check("xfer_ovf", 32'(bus.ovf), 32'(e.o));
            end
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!bus.valid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.valid) begin
            n_checks++;
            $display("FAIL valid_timeout: got valid=0 expected valid=1 within 40 cycles");
        end
    endtask

    task automatic convert(input logic [N-1:0] d, input logic [N-1:0] e, input logic eo);
        exp_q.push_back('{e, eo});
        din_set(d);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid();
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_dout_hold", 32'(bus.dout), 32'(e));
        check("idle_ovf", 32'(bus.ovf), 32'd0);
    endtask

    task automatic din_set(input logic [N-1:0] d);
        bus.din = d;
        arr_b   = d;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ack   = 1'b1;
        bus.din   = '0;
        arr_b     = '0;
        #2;
        check("rst_T", 32'(T), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        tick();
        rst = 1'b0;

        // Exact timing: T walk, latency of 2*N+1 edges, result 0xFB.
        exp_q.push_back('{8'hFB, 1'b0});
        din_set(8'h05);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("clear_T", 32'(T), 32'h001);
        check("clear_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= N; k++) begin
            tick();
            check($sformatf("pulse_T%0d", k), 32'(T), 32'd1 << k);
        end
        for (int c = 0; c < N; c++) begin
            tick();
            check("inc_T", 32'(T), 32'd0);
            check("inc_valid", 32'(bus.valid), 32'd0);
        end
        tick();
        check("edge17_valid", 32'(bus.valid), 32'd1);
        check("done_T", 32'(T), 32'd0);
        tick();
        check("after_ack_busy", 32'(bus.busy), 32'd0);

        // Boundary operands.
        convert(8'h00, 8'h00, 1'b0);
        convert(8'hFF, 8'h01, 1'b0);
        convert(8'h80, 8'h80, 1'b1);

        // Hold in DONE with ack low; start pulses must be ignored.
        bus.ack = 1'b0;
        exp_q.push_back('{8'hFB, 1'b0});
        din_set(8'h05);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(bus.valid), 32'd1);
            check("hold_dout", 32'(bus.dout), 32'hFB);
            bus.start = 1'b1;
            bus.din   = 8'h22;
            tick();
        end
        bus.ack = 1'b1;
        check("hold_valid6", 32'(bus.valid), 32'd1);
        check("hold_dout6", 32'(bus.dout), 32'hFB);
        tick();
        check("hold_exit_busy", 32'(bus.busy), 32'd0);
        check("hold_exit_valid", 32'(bus.valid), 32'd0);
        bus.start = 1'b0;
        tick();
        check("start_ignored", 32'(bus.busy), 32'd0);

        // Asynchronous reset during the T[4] cycle.
        din_set(8'h55);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("pre_rst_T4", 32'(T), 32'h010);
        #2;
        rst = 1'b1;
        #1;
        check("arst_T", 32'(T), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_valid", 32'(bus.valid), 32'd0);
        tick();
        rst = 1'b0;
        convert(8'h01, 8'hFF, 1'b0);

        // Back-to-back with start held high.
        exp_q.push_back('{8'hFD, 1'b0});
        exp_q.push_back('{8'h81, 1'b0});
        din_set(8'h03);
        bus.start = 1'b1;
        tick();
        bus.din = 8'h7F;
        wait_valid();
        tick();
        check("b2b_idle", 32'(bus.busy), 32'd0);
        arr_b = 8'h7F;
        tick();
        check("b2b_accept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_valid();
        tick();
        check("b2b_done_idle", 32'(bus.busy), 32'd0);

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/twos_comp_seq.md
TWOS_COMP_SEQ -- requirements
Module: twos_comp_seq

Interface
REQ-001 SHALL have parameter N_BITS, default 8: operand width.
REQ-002 SHALL have parameter PULSES, default 9: timing-pulse vector width, fixed at N_BITS+1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  request to convert din; accepted only in IDLE.
REQ-006 SHALL have port din  input  N_BITS  operand, sampled on the edge that accepts start.
REQ-007 SHALL have port T  output  PULSES  timing pulses to the one's-complement latch array: T[0] clears all bits, T[k] sets bit k-1.
REQ-008 SHALL have port bbar_in  input  N_BITS  one's-complement latch outputs returned from the array.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port dout  output  N_BITS  two's-complement result.
REQ-011 SHALL have port valid  output  1  dout is valid.
REQ-012 SHALL have port ack  input  1  consumer accepts dout.
REQ-013 SHALL have port ovf  output  1  operand was the most negative value (only 1 followed by N_BITS-1 zeros).

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, PULSE, INC, DONE.
REQ-015 In IDLE, start=1 at an edge SHALL capture din into a hold register and enter CLEAR; start=0 SHALL stay in IDLE.
REQ-016 CLEAR SHALL last exactly one cycle with T = 1 (T[0] only), then enter PULSE with pulse index k=1.
REQ-017 PULSE SHALL last N_BITS cycles, driving T[k] alone during the cycle for index k and driving the held bit din[k-1] on the array's B inputs via the hold register (the array input is the hold register bits, exported by the integration wrapper), then incrementing k.
REQ-018 T SHALL be one-hot during CLEAR and PULSE and all-zero in IDLE, INC and DONE.
REQ-019 On the edge ending the T[N_BITS] cycle, the block SHALL load a work register from bbar_in, set carry=1, set bit index i=0, and enter INC.
REQ-020 INC SHALL process one bit per cycle, LSB first: work[i] <= work[i] XOR carry; carry <= work[i] AND carry; i increments; it SHALL run exactly N_BITS cycles with no early exit.
REQ-021 The final carry-out SHALL be discarded (result modulo 2^N_BITS).
REQ-022 After the last INC cycle the FSM SHALL enter DONE with valid=1 and dout=work.
REQ-023 Latency: with start accepted at edge E0, valid SHALL first be high after edge E0+2*N_BITS+1 (edge 17 for N_BITS=8).
REQ-024 valid and dout SHALL hold stable in DONE until ack=1 at an edge; the FSM then returns to IDLE and valid falls.
REQ-025 ack outside DONE SHALL be ignored.
REQ-026 start while busy=1 SHALL be ignored, including in the DONE cycle in which ack is taken; a new start is accepted no earlier than the first IDLE cycle.
REQ-027 ovf SHALL equal (held din == 2^(N_BITS-1)) and SHALL be valid while valid=1, and 0 otherwise.
REQ-028 dout SHALL retain the last result in IDLE until the next conversion's INC load.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force state IDLE, T=0, busy=0, valid=0, ovf=0, dout=0, and clear the hold register, work register, carry and indices.
REQ-030 Reset asserted during any state, including mid-PULSE, SHALL abandon the conversion; the array's stale latch contents SHALL be cleared by the next CLEAR.
REQ-031 After rst deasserts, the first start SHALL be accepted at the first rising edge with start=1.

Verification
REQ-032 din=0x05, start one cycle, ack tied 1 -> T sequence 0x001,0x002,...,0x100 on consecutive cycles; valid at edge 17; dout=0xFB; ovf=0.
REQ-033 din=0x00 -> dout=0x00, ovf=0; din=0xFF -> dout=0x01; din=0x80 -> dout=0x80, ovf=1.
REQ-034 ack held 0 for 5 cycles in DONE, then 1 -> valid and dout=0xFB stable for all 6 cycles; IDLE on the next edge; start pulsed during the same interval -> ignored.
REQ-035 rst asserted asynchronously during the T[4] cycle -> T=0, busy=0 and valid=0 without an edge; a subsequent conversion with din=0x01 -> dout=0xFF.
REQ-036 Back-to-back: start held high continuously, ack=1 -> conversions of 0x03 then 0x7F yield 0xFD then 0x81; the second start is accepted on the first IDLE edge.
